// File: rtl/memory_arbiter.sv
// Serialises instruction fetches and data loads/stores from the datapath onto a
// single-port RAM. Data requests win in IDLE; each served request gets one hit pulse.
module memory_arbiter #(
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        bus_err
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [7:0] RETRY_LAST   = 8'(MAX_RETRY - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DREQ, IREQ, DONE} state_t;

    state_t      state;
    logic        is_store;
    logic        backoff;
    logic [7:0]  retry_cnt;
    logic [7:0]  timeout_cnt;
    logic        req_live;
    logic        finish_req;
    logic        finish_err;
    logic [31:0] finish_word;

    assign req_live = (state == DREQ) ? (dmemREN | dmemWEN) : imemREN;

    // The cycle after an ERROR is a dead cycle with strobes low, so ramstate is ignored there.
    always_comb begin
        finish_req  = 1'b0;
        finish_err  = 1'b0;
        finish_word = '0;
        if (!backoff) begin
            case (ramstate)
                RAM_ACCESS: begin
                    finish_req  = 1'b1;
                    finish_word = ramload;
                end
                RAM_ERROR: begin
                    if (retry_cnt == RETRY_LAST) begin
                        finish_req = 1'b1;
                        finish_err = 1'b1;
                    end
                end
                default: begin
                    if (timeout_cnt == TIMEOUT_LAST) begin
                        finish_req = 1'b1;
                        finish_err = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            ihit        <= 1'b0;
            dhit        <= 1'b0;
            ramREN      <= 1'b0;
            ramWEN      <= 1'b0;
            bus_err     <= 1'b0;
            imemload    <= '0;
            dmemload    <= '0;
            ramaddr     <= '0;
            ramstore    <= '0;
            is_store    <= 1'b0;
            backoff     <= 1'b0;
            retry_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmemREN | dmemWEN) begin
                        ramaddr  <= dmemaddr;
                        ramstore <= dmemstore;
                        is_store <= dmemWEN;
                        if (dmemaddr[1:0] != 2'b00) begin
                            state    <= DONE;
                            dhit     <= 1'b1;
                            dmemload <= '0;
                            bus_err  <= 1'b1;
                        end else begin
                            state  <= DREQ;
                            ramREN <= ~dmemWEN;
                            ramWEN <= dmemWEN;
                        end
                    end else if (imemREN) begin
                        ramaddr  <= imemaddr;
                        is_store <= 1'b0;
                        state    <= IREQ;
                        ramREN   <= 1'b1;
                    end
                end
                DREQ, IREQ: begin
                    if (!req_live) begin
                        state       <= IDLE;
                        ramREN      <= 1'b0;
                        ramWEN      <= 1'b0;
                        backoff     <= 1'b0;
                        retry_cnt   <= '0;
                        timeout_cnt <= '0;
                    end else if (backoff) begin
                        backoff <= 1'b0;
                        ramREN  <= ~is_store;
                        ramWEN  <= is_store;
                    end else if (finish_req) begin
                        state  <= DONE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        if (finish_err)
                            bus_err <= 1'b1;
                        if (state == DREQ) begin
                            dhit <= 1'b1;
                            if (!is_store)
                                dmemload <= finish_word;
                        end else begin
                            ihit     <= 1'b1;
                            imemload <= finish_word;
                        end
                    end else if (ramstate == RAM_ERROR) begin
                        retry_cnt <= retry_cnt + 8'd1;
                        backoff   <= 1'b1;
                        ramREN    <= 1'b0;
                        ramWEN    <= 1'b0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    ihit        <= 1'b0;
                    dhit        <= 1'b0;
                    backoff     <= 1'b0;
                    retry_cnt   <= '0;
                    timeout_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: table of single transactions served by a scripted
// RAM, then hand-written priority, withdrawal and mid-request reset sequences.
module tb_memory_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN, dmemREN, dmemWEN;
    logic [31:0] imemaddr, dmemaddr, dmemstore;
    logic        ihit, dhit, ramREN, ramWEN, bus_err;
    logic [31:0] imemload, dmemload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int compared   = 0;
    int mismatched = 0;
    int overlap    = 0;

    logic        got_i, got_d, hit_err;
    logic [31:0] hit_word, hit_addr, hit_store;
    int          hit_cycle, ren_cnt, wen_cnt;

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] rload;
        int          busy;
        int          errs;
        logic        exp_i;
        logic        exp_d;
        logic        chk_word;
        logic [31:0] exp_word;
        logic [31:0] exp_addr;
        int          exp_cycle;
        int          exp_ren;
        int          exp_wen;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    memory_arbiter #(.MAX_RETRY(3), .TIMEOUT(255)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Scripted RAM: while a strobe is up, answer ERROR, then BUSY, then ACCESS.
    // Cycle 1 is the cycle the request is presented in IDLE.
    task automatic waitHit(input int busy_in, input int errs_in, input logic [31:0] rload);
        int  busy = busy_in;
        int  errs = errs_in;
        bit  done = 1'b0;
        got_i = 1'b0; got_d = 1'b0; hit_err = 1'b0;
        ren_cnt = 0; wen_cnt = 0; hit_cycle = 0;
        ramload = rload;
        for (int c = 2; c <= 400; c++) begin
            @(negedge CLK);
            if (ihit && dhit)
                overlap++;
            if (ihit || dhit) begin
                got_i     = ihit;
                got_d     = dhit;
                hit_cycle = c;
                hit_word  = ihit ? imemload : dmemload;
                hit_addr  = ramaddr;
                hit_store = ramstore;
                hit_err   = bus_err;
                ramstate  = FREE;
                done      = 1'b1;
                break;
            end else if (ramREN || ramWEN) begin
                if (ramREN) ren_cnt++;
                if (ramWEN) wen_cnt++;
                if (errs > 0) begin
                    ramstate = ERROR;
                    errs--;
                end else if (busy > 0) begin
                    ramstate = BUSY;
                    busy--;
                end else begin
                    ramstate = ACCESS;
                end
            end else begin
                ramstate = FREE;
            end
        end
        if (!done)
            checkOutput("hit_arrival", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge CLK);
        ramstate  = FREE;
        imemREN   = v.iren;
        imemaddr  = v.iaddr;
        dmemREN   = v.dren;
        dmemWEN   = v.dwen;
        dmemaddr  = v.daddr;
        dmemstore = v.dstore;
        waitHit(v.busy, v.errs, v.rload);
        imemREN = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    initial begin
        int hits;

        //           iren  iaddr       dren  dwen  daddr        dstore        rload        busy errs exp_i exp_d chkw  exp_word      exp_addr    cyc ren wen err
        vecs[0] = '{1'b1, 32'h40,     1'b0, 1'b0, 32'h0,       32'h0,        32'h00500093, 0,   0,  1'b1, 1'b0, 1'b1, 32'h00500093, 32'h40,     3,  1,  0, 1'b0};
        vecs[1] = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h100,     32'h0,        32'h12345678, 1,   0,  1'b0, 1'b1, 1'b1, 32'h12345678, 32'h100,    4,  2,  0, 1'b0};
        vecs[2] = '{1'b0, 32'h0,      1'b0, 1'b1, 32'h200,     32'hDEADBEEF, 32'h0,        2,   0,  1'b0, 1'b1, 1'b0, 32'h0,        32'h200,    5,  0,  3, 1'b0};
        vecs[3] = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h204,     32'hCAFEF00D, 32'h11111111, 0,   0,  1'b0, 1'b1, 1'b0, 32'h0,        32'h204,    3,  0,  1, 1'b0};
        vecs[4] = '{1'b1, 32'h44,     1'b0, 1'b0, 32'h0,       32'h0,        32'h87654321, 3,   0,  1'b1, 1'b0, 1'b1, 32'h87654321, 32'h44,     6,  4,  0, 1'b0};
        vecs[5] = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h300,     32'h0,        32'hA5A5A5A5, 0,   2,  1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h300,    7,  3,  0, 1'b0};
        vecs[6] = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h304,     32'h0,        32'hFFFFFFFF, 0,   3,  1'b0, 1'b1, 1'b1, 32'h0,        32'h304,    7,  3,  0, 1'b1};
        vecs[7] = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h102,     32'h0,        32'hFFFFFFFF, 0,   0,  1'b0, 1'b1, 1'b1, 32'h0,        32'h102,    2,  0,  0, 1'b1};
        vecs[8] = '{1'b0, 32'h0,      1'b0, 1'b1, 32'h201,     32'h0BADF00D, 32'h0,        0,   0,  1'b0, 1'b1, 1'b0, 32'h0,        32'h201,    2,  0,  0, 1'b1};
        vecs[9] = '{1'b1, 32'h48,     1'b0, 1'b0, 32'h0,       32'h0,        32'h13579BDF, 1000, 0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h48,     257, 255, 0, 1'b1};

        nRST = 1'b0;
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        imemaddr = '0; dmemaddr = '0; dmemstore = '0;
        ramload = '0; ramstate = FREE;
        repeat (2) @(negedge CLK);
        checkOutput("reset_strobes_hits", {27'd0, ihit, dhit, ramREN, ramWEN, bus_err}, 32'd0);
        checkOutput("reset_ramaddr", ramaddr, 32'd0);
        checkOutput("reset_loads", imemload | dmemload | ramstore, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);
        checkOutput("idle_after_reset", {30'd0, ramREN, ihit}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_ihit", i), {31'd0, got_i}, {31'd0, vecs[i].exp_i});
            checkOutput($sformatf("v%0d_dhit", i), {31'd0, got_d}, {31'd0, vecs[i].exp_d});
            if (vecs[i].chk_word)
                checkOutput($sformatf("v%0d_load_word", i), hit_word, vecs[i].exp_word);
            checkOutput($sformatf("v%0d_ramaddr", i), hit_addr, vecs[i].exp_addr);
            if (vecs[i].dwen)
                checkOutput($sformatf("v%0d_ramstore", i), hit_store, vecs[i].dstore);
            checkOutput($sformatf("v%0d_hit_cycle", i), 32'(hit_cycle), 32'(vecs[i].exp_cycle));
            checkOutput($sformatf("v%0d_ren_cycles", i), 32'(ren_cnt), 32'(vecs[i].exp_ren));
            checkOutput($sformatf("v%0d_wen_cycles", i), 32'(wen_cnt), 32'(vecs[i].exp_wen));
            checkOutput($sformatf("v%0d_bus_err", i), {31'd0, hit_err}, {31'd0, vecs[i].exp_err});
        end

        // Data and fetch raised together: data first, then the fetch, never overlapping.
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h50;
        dmemREN = 1'b1; dmemaddr = 32'h100;
        waitHit(0, 0, 32'h0000AAAA);
        dmemREN = 1'b0;
        checkOutput("prio_first_dhit", {30'd0, got_i, got_d}, 32'd1);
        checkOutput("prio_first_addr", hit_addr, 32'h100);
        checkOutput("prio_first_word", hit_word, 32'h0000AAAA);
        waitHit(0, 0, 32'h0000BBBB);
        imemREN = 1'b0;
        checkOutput("prio_second_ihit", {30'd0, got_i, got_d}, 32'd2);
        checkOutput("prio_second_addr", hit_addr, 32'h50);
        checkOutput("prio_second_word", hit_word, 32'h0000BBBB);
        checkOutput("hit_overlap", 32'(overlap), 32'd0);

        // Fetch withdrawn while the RAM is busy: strobe drops and no hit follows.
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h60; ramstate = BUSY;
        repeat (2) @(negedge CLK);
        checkOutput("withdraw_ren_up", {31'd0, ramREN}, 32'd1);
        imemREN = 1'b0;
        @(negedge CLK);
        checkOutput("withdraw_ren_down", {31'd0, ramREN}, 32'd0);
        hits = 0;
        repeat (4) begin
            @(negedge CLK);
            if (ihit || dhit) hits++;
        end
        checkOutput("withdraw_no_hit", 32'(hits), 32'd0);

        // Reset asserted mid-fetch clears everything at once; no hit after release.
        ramstate = BUSY;
        imemREN = 1'b1; imemaddr = 32'h70;
        repeat (2) @(negedge CLK);
        checkOutput("pre_reset_ren", {31'd0, ramREN}, 32'd1);
        nRST = 1'b0;
        #1;
        checkOutput("async_reset_flags", {27'd0, ihit, dhit, ramREN, ramWEN, bus_err}, 32'd0);
        checkOutput("async_reset_ramaddr", ramaddr, 32'd0);
        checkOutput("async_reset_loads", imemload | dmemload, 32'd0);
        imemREN = 1'b0;
        ramstate = FREE;
        @(negedge CLK);
        nRST = 1'b1;
        hits = 0;
        repeat (5) begin
            @(negedge CLK);
            if (ihit || dhit || ramREN) hits++;
        end
        checkOutput("post_reset_quiet", 32'(hits), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
